pipe_stage_reg: RTL
===================

# pipe_stage_reg

Generic, parametrised pipeline stage register for the MIPS pipeline. It replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB latches with a single block. The block carries a control word and a data payload, and adds a valid/ready handshake, stall, and flush. Invalid stages present a bubble control word, so downstream stages never write state. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- DATA_W, 96, payload width (e.g. ALUResult + ReadData2 + NextPC)
- CTRL_W, 10, control-word width (PCSrc, RegWr, MemWr, MemRd, MemToReg, ...)
- CTRL_BUBBLE, all-zero, control value driven whenever the stage holds no valid entry
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  kill all held entries (branch/exception)
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control word
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage holds a valid entry
- out_ready  in  1  downstream accepts (low = stall)
- out_ctrl  out  CTRL_W  control word; CTRL_BUBBLE when out_valid=0
- out_data  out  DATA_W  payload; held (don't-care) when out_valid=0
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Accept when in_valid & in_ready; transfer out when out_valid & out_ready.
- Base mode (single entry):
  - in_ready = ~out_valid | out_ready (combinational).
  - On accept, load in_ctrl/in_data and set out_valid.
  - On transfer without a new accept, clear out_valid.
- Bubble: out_ctrl is muxed to CTRL_BUBBLE whenever out_valid=0. Data registers are not cleared.
- Flush:
  - Next edge clears all valid bits. Any simultaneous accept is discarded.
  - A transfer in the flush cycle still completes downstream. Flush only affects the entries held after the edge.
- Stall counter:
  - Increments on every cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Flush does not clear it; only reset does.
- Reset (asynchronous, active-low):
  - out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, stall_cnt=0, skid entry invalid.
  - in_ready=1 once reset deasserts.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N; full throughput is 1 entry/cycle.
- Base mode: in_ready depends combinationally on out_ready (one gate).
- With skid (see Configuration):
  - in_ready is registered and equals ~skid_valid.
  - If the main entry stalls while in_ready=1, the incoming entry goes to the skid buffer and in_ready drops the next cycle.
  - When out_ready rises, the main entry transfers and the skid entry moves to main on the same edge.
  - in_ready returns high one cycle later.
  - Order is strictly preserved.
- Simultaneous accept and transfer with a full main entry (skid empty): the new entry replaces main, and the skid is unused.
- Reset mid-stall drops all entries immediately (asynchronous). No partial state remains.

## Configuration
- PIPE_SKID_EN:
  - Defined: a two-entry skid buffer with registered in_ready, breaking the ready path between stages.
  - Undefined: a single entry with combinational in_ready, giving minimum area.
- Latency and ordering are identical in both builds; only the in_ready timing differs.

## Structure
- Shared package pipe_pkg:
  - Per-stage control-word structs (ex_mem_ctrl_t etc.) with their widths.
  - The bubble constants.
  - The stall-counter width.
- Sub-module pipe_skid_buf holds the second entry and its valid bit. It is instantiated only under PIPE_SKID_EN.
- Top level keeps the main register, bubble mux, flush logic and stall counter.

## Test plan
- Reset low mid-operation: out_valid=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0 immediately. in_ready=1 once reset deasserts.
- Back-to-back stream, data 1..8, out_ready=1: out_data 1..8 on consecutive cycles, 1-cycle latency, no gaps.
- Hold out_ready=0 for 5 cycles with a valid entry:
  - stall_cnt=5.
  - Base mode: in_ready=0.
  - Skid mode: one extra entry is accepted, then in_ready=0, and no entry is lost or reordered on release.
- Assert flush together with in_valid=1 (data 0xAA): 0xAA is never presented. out_valid=0 and out_ctrl=CTRL_BUBBLE next cycle.
- Preload stall_cnt near max (CNT_W=4, 20 stall cycles): the counter holds at 15.
- Random in_valid/out_ready for 10k cycles, checked against a scoreboard: output sequence equals accepted sequence minus flushed entries. Repeat in both builds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline definitions: per-stage control words, bubble values, counter width.
package pipe_pkg;

  localparam int PIPE_CNT_W = 16;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_wr;
    logic       mem_rd;
    logic       mem_to_reg;
    logic       reg_wr;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       pc_src;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic       mem_to_reg;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       branch;
    logic       jump;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_wr;
  } mem_wb_ctrl_t;

  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

  // Bubbles must deassert every write enable; all-zero does that for every stage.
  localparam id_ex_ctrl_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_ctrl_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Second (overflow) entry of a pipeline stage: catches the entry accepted while main stalls.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = EX_MEM_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              skid_valid,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [DATA_W-1:0] skid_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else begin
      if (flush)      skid_valid <= 1'b0;
      else if (load)  skid_valid <= 1'b1;
      else if (drain) skid_valid <= 1'b0;
      if (load) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with handshake, flush, bubble control and stall counter.
// Define PIPE_SKID_EN for a two-entry skid version with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 10,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 CNT_W       = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              accept, xfer;
  logic              main_load;
  logic [CTRL_W-1:0] nxt_ctrl;
  logic [DATA_W-1:0] nxt_data;

  assign accept = in_valid & in_ready;
  assign xfer   = main_valid & out_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load, skid_drain;

  // in_ready comes straight from a flop, so upstream sees no combinational path.
  assign in_ready   = ~skid_valid;
  assign skid_load  = accept & main_valid & ~out_ready & ~flush;
  assign skid_drain = skid_valid & xfer;

  always_comb begin
    main_load = 1'b0;
    nxt_ctrl  = in_ctrl;
    nxt_data  = in_data;
    if (!flush) begin
      if (skid_drain) begin
        main_load = 1'b1;
        nxt_ctrl  = skid_ctrl;
        nxt_data  = skid_data;
      end else if (accept && (!main_valid || out_ready)) begin
        main_load = 1'b1;
      end
    end
  end

  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (skid_load),
    .drain      (skid_drain),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .skid_valid (skid_valid),
    .skid_ctrl  (skid_ctrl),
    .skid_data  (skid_data)
  );
`else
  assign in_ready = ~main_valid | out_ready;

  always_comb begin
    main_load = accept & ~flush;
    nxt_ctrl  = in_ctrl;
    nxt_data  = in_data;
  end
`endif

  // Flush wins over any same-cycle accept; a same-cycle transfer has already happened downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else begin
      if (flush)          main_valid <= 1'b0;
      else if (main_load) main_valid <= 1'b1;
      else if (xfer)      main_valid <= 1'b0;
      if (main_load) begin
        main_ctrl <= nxt_ctrl;
        main_data <= nxt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;
  assign out_data  = main_data;

endmodule
